uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- UART transceiver plus byte-stream command decoder.
- Receives 8N1 serial bytes from a host and echoes each received byte back on tx_o.
- Parses command packets that update pattern, frequency, period, repeat and control registers for the serial-output channels downstream.
- Sits between the host UART pins and the pattern-generator core.

Parameters:
- SYS_CLK, 50000000: system clock frequency in Hz.
- BAUD_RATE, 115200: UART bit rate.
- DATA_BIT, 32: width of the data and frequency patterns.
- PACK_NUM, 4: bytes per pattern (DATA_BIT/8).
- STOP_BIT, 1: number of UART stop bits.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-high.
- rx_i, input, 1: UART serial input, idles high.
- tx_o, output, 1: UART echo output, idles high.
- rx_done_tick_o, output, 1: one-cycle pulse when a byte is received.
- rx_data_o, output, 8: last received byte.
- tx_done_tick_o, output, 1: one-cycle pulse at the end of the echo stop bit.
- output_pattern_o, output, DATA_BIT: data pattern.
- freq_pattern_o, output, DATA_BIT: per-bit fast/slow select pattern.
- sel_out_o, output, 8: channel index of the last DATA/CTRL/REPEAT command.
- mode_o, output, 2: 00 one-shot, 01 continue, 10 repeat.
- enable_o, output, 1: channel enable.
- stop_o, output, 1: stop level.
- idle_o, output, 1: output idle level.
- slow_period_o, output, 8: slow period.
- fast_period_o, output, 8: fast period.
- repeat_o, output, 8: repeat count.
- cmd_o, output, 8: last completed command code.
- done_tick_o, output, 1: one-cycle pulse when a command completes.

Behaviour:
- Baud generator: tick every round(SYS_CLK/(16*BAUD_RATE)) clocks, which is 27 at the defaults. Both RX and TX oversample 16x.
- RX FSM (IDLE, START, DATA, STOP):
  - A falling edge on rx_i starts reception; rx_i is two-flop synchronized first.
  - The start bit is re-checked at mid-bit (8 ticks); if rx_i is high there, return to IDLE (glitch).
  - Data bits are sampled LSB first at mid-bit, every 16 ticks.
  - After the STOP_BIT*16 stop ticks, pulse rx_done_tick_o and update rx_data_o. No framing-error flag; a bad stop bit is still accepted.
- TX echo:
  - A byte transmits whenever rx_done_tick_o fires and TX is idle. A start request while TX is busy is dropped.
  - Frame: start bit 0, 8 data bits LSB first, then the stop bit(s).
  - tx_done_tick_o pulses after the last stop bit.
- Command codes: 0x01 DATA, 0x02 FREQ, 0x03 PERIOD, 0x04 CTRL, 0x05 REPEAT. In IDLE, any other byte is ignored.
- Decoder FSM (IDLE, PAYLOAD): a valid command byte in IDLE latches the command and the expected payload length, and resets the byte counter. Payloads, in arrival order:
  - DATA: channel, then PACK_NUM data bytes LSB byte first.
  - FREQ: PACK_NUM bytes, LSB byte first.
  - PERIOD: slow byte, then fast byte.
  - CTRL: channel, then ctrl byte with bit0 enable, bits2:1 mode, bit3 idle, bit4 stop; bits7:5 are ignored.
  - REPEAT: channel, then repeat count.
- Payload bytes go to shadow registers. Outputs update only when the final payload byte arrives, so a partial packet never alters outputs.
- On the cycle after the final byte's rx_done tick: outputs update, cmd_o takes the command code, done_tick_o pulses for 1 cycle, FSM returns to IDLE.
- sel_out_o is updated by DATA, CTRL and REPEAT only.
- Payload bytes are never interpreted as commands, including byte values 0x01 to 0x05.
- Reset values: all decoder outputs 0, tx_o 1, rx_data_o 0, FSMs in IDLE. Reset mid-packet discards the partial packet.

Optional Feature:
- Macro UART_CMD_TIMEOUT_EN.
- When defined: an inter-byte counter runs in PAYLOAD. If no byte arrives within 20 bit periods (320 baud ticks), the FSM aborts to IDLE with outputs unchanged and no done_tick_o.
- When undefined: PAYLOAD waits indefinitely.

Test Plan:
- Each received byte is echoed on tx_o unchanged; rx_done_tick_o and tx_done_tick_o each pulse exactly once per byte.
- PERIOD packet 03,14,05 -> slow_period_o=0x14, fast_period_o=0x05, cmd_o=0x03, one done_tick_o.
- FREQ packet 02,44,33,22,11 -> freq_pattern_o=0x11223344. Outputs stay unchanged until the last byte arrives.
- DATA packet 01,05,EE,DD,CC,BB -> sel_out_o=5, output_pattern_o=0xBBCCDDEE.
- REPEAT packet 05,05,03 -> repeat_o=3. CTRL packet 04,05,0B -> idle_o=1, mode_o=01, enable_o=1, stop_o=0.
- Edge cases:
  - Byte 0x7F in IDLE -> ignored.
  - Reset asserted after 03,14 -> outputs 0.
  - With UART_CMD_TIMEOUT_EN, 02 then silence -> timeout; a subsequent 03,01,02 decodes correctly.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder_if
// Bundles the host serial pins, the receive/transmit status pulses and the
// decoded register outputs of uart_cmd_decoder into one interface.
//   rx_i / tx_o               : host UART pins (both idle high)
//   rx_done_tick_o, rx_data_o : byte-received pulse and last received byte
//   tx_done_tick_o            : end of the echo frame
//   output_pattern_o .. cmd_o : decoded registers for the pattern channels
//   done_tick_o               : one-cycle pulse when a command completes
// Modports:
//   master : the host / pattern-core side (drives rx_i, observes the rest)
//   slave  : the decoder itself
// ---------------------------------------------------------------------------
interface uart_cmd_decoder_if #(
   parameter int DATA_BIT = 32
);
   logic                rx_i;
   logic                tx_o;
   logic                rx_done_tick_o;
   logic [7:0]          rx_data_o;
   logic                tx_done_tick_o;
   logic [DATA_BIT-1:0] output_pattern_o;
   logic [DATA_BIT-1:0] freq_pattern_o;
   logic [7:0]          sel_out_o;
   logic [1:0]          mode_o;
   logic                enable_o;
   logic                stop_o;
   logic                idle_o;
   logic [7:0]          slow_period_o;
   logic [7:0]          fast_period_o;
   logic [7:0]          repeat_o;
   logic [7:0]          cmd_o;
   logic                done_tick_o;

   modport master (
      output rx_i,
      input  tx_o, rx_done_tick_o, rx_data_o, tx_done_tick_o,
             output_pattern_o, freq_pattern_o, sel_out_o, mode_o,
             enable_o, stop_o, idle_o, slow_period_o, fast_period_o,
             repeat_o, cmd_o, done_tick_o
   );

   modport slave (
      input  rx_i,
      output tx_o, rx_done_tick_o, rx_data_o, tx_done_tick_o,
             output_pattern_o, freq_pattern_o, sel_out_o, mode_o,
             enable_o, stop_o, idle_o, slow_period_o, fast_period_o,
             repeat_o, cmd_o, done_tick_o
   );
endinterface

// File: rtl/uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder
// 8N1 UART receiver with byte echo on tx_o, followed by a command decoder
// that turns DATA/FREQ/PERIOD/CTRL/REPEAT packets into register outputs for
// the downstream pattern-generator channels.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active HIGH despite the legacy name
//   bus   : uart_cmd_decoder_if.slave (serial pins, status pulses, registers)
// Optional build macro:
//   UART_CMD_TIMEOUT_EN : abort a packet if no byte arrives for 320 baud
//                         ticks (20 bit periods) while waiting for payload.
// ---------------------------------------------------------------------------
module uart_cmd_decoder #(
   parameter int SYS_CLK   = 50000000,
   parameter int BAUD_RATE = 115200,
   parameter int DATA_BIT  = 32,
   parameter int PACK_NUM  = 4,
   parameter int STOP_BIT  = 1
) (
   input logic               clk,
   input logic               rst_n,
   uart_cmd_decoder_if.slave bus
);
   // Rounded divider so the 16x oversampling tick is as close as possible.
   localparam int BAUD_DIV   = (SYS_CLK + 8 * BAUD_RATE) / (16 * BAUD_RATE);
   localparam int DIV_W      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int STOP_TICKS = STOP_BIT * 16;

   localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
   localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
   localparam logic [0:0] DEC_IDLE = 1'b0, DEC_PAYLOAD = 1'b1;

   localparam logic [7:0] CMD_DATA = 8'h01, CMD_FREQ = 8'h02, CMD_PERIOD = 8'h03;
   localparam logic [7:0] CMD_CTRL = 8'h04, CMD_REPEAT = 8'h05;
   localparam logic [7:0] DATA_LEN = 8'(PACK_NUM + 1);
   localparam logic [7:0] FREQ_LEN = 8'(PACK_NUM);

   logic [DIV_W-1:0]    baud_cnt;
   logic                tick;
   logic                rx_meta, rx_sync, rx_prev;
   logic [1:0]          rx_state;
   logic [7:0]          rx_scnt;
   logic [2:0]          rx_ncnt;
   logic [7:0]          rx_shift, rx_data;
   logic                rx_done;
   logic [1:0]          tx_state;
   logic [7:0]          tx_scnt;
   logic [2:0]          tx_ncnt;
   logic [7:0]          tx_shift;
   logic                tx_line, tx_done;
   logic [0:0]          dec_state;
   logic [7:0]          cmd_reg, len_reg, byte_cnt, sh_first;
   logic [DATA_BIT-9:0] sh_data;
   logic                cmd_valid;
   logic [7:0]          cmd_len;
   logic [DATA_BIT-1:0] pattern, freq;
   logic [7:0]          sel, slow, fast, rep, cmd_out;
   logic [1:0]          mode;
   logic                enable, stop, idle, done_tick;
`ifdef UART_CMD_TIMEOUT_EN
   logic [8:0]          idle_cnt;
`endif

   // Free-running baud divider; tick is a one-clock strobe at 16x baud.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         baud_cnt <= '0;
         tick     <= 1'b0;
      end else if (baud_cnt == DIV_W'(BAUD_DIV - 1)) begin
         baud_cnt <= '0;
         tick     <= 1'b1;
      end else begin
         baud_cnt <= baud_cnt + 1'b1;
         tick     <= 1'b0;
      end
   end

   // Two-flop synchronizer plus one extra stage to see the start-bit edge.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= bus.rx_i;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Receiver: start bit is re-checked at mid-bit to reject glitches, data is
   // sampled at mid-bit LSB first; the stop bit is not checked.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rx_state <= RX_IDLE;
         rx_scnt  <= '0;
         rx_ncnt  <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         rx_done  <= 1'b0;
      end else begin
         rx_done <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_sync) begin
                  rx_state <= RX_START;
                  rx_scnt  <= '0;
               end
            end
            RX_START: begin
               if (tick) begin
                  if (rx_scnt == 8'd7) begin
                     rx_scnt  <= '0;
                     rx_ncnt  <= '0;
                     rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                  end else begin
                     rx_scnt <= rx_scnt + 8'd1;
                  end
               end
            end
            RX_DATA: begin
               if (tick) begin
                  if (rx_scnt == 8'd15) begin
                     rx_scnt  <= '0;
                     rx_shift <= {rx_sync, rx_shift[7:1]};
                     if (rx_ncnt == 3'd7) rx_state <= RX_STOP;
                     else                 rx_ncnt  <= rx_ncnt + 3'd1;
                  end else begin
                     rx_scnt <= rx_scnt + 8'd1;
                  end
               end
            end
            default: begin
               if (tick) begin
                  if (rx_scnt == 8'(STOP_TICKS - 1)) begin
                     rx_state <= RX_IDLE;
                     rx_done  <= 1'b1;
                     rx_data  <= rx_shift;
                  end else begin
                     rx_scnt <= rx_scnt + 8'd1;
                  end
               end
            end
         endcase
      end
   end

   // Echo transmitter: a received byte is only taken when TX is idle, so a
   // byte arriving mid-frame is silently dropped.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         tx_state <= TX_IDLE;
         tx_scnt  <= '0;
         tx_ncnt  <= '0;
         tx_shift <= '0;
         tx_line  <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               if (rx_done) begin
                  tx_shift <= rx_data;
                  tx_line  <= 1'b0;
                  tx_scnt  <= '0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tick) begin
                  if (tx_scnt == 8'd15) begin
                     tx_scnt  <= '0;
                     tx_ncnt  <= '0;
                     tx_line  <= tx_shift[0];
                     tx_state <= TX_DATA;
                  end else begin
                     tx_scnt <= tx_scnt + 8'd1;
                  end
               end
            end
            TX_DATA: begin
               if (tick) begin
                  if (tx_scnt == 8'd15) begin
                     tx_scnt  <= '0;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     if (tx_ncnt == 3'd7) begin
                        tx_line  <= 1'b1;
                        tx_state <= TX_STOP;
                     end else begin
                        tx_ncnt <= tx_ncnt + 3'd1;
                        tx_line <= tx_shift[1];
                     end
                  end else begin
                     tx_scnt <= tx_scnt + 8'd1;
                  end
               end
            end
            default: begin
               if (tick) begin
                  if (tx_scnt == 8'(STOP_TICKS - 1)) begin
                     tx_state <= TX_IDLE;
                     tx_done  <= 1'b1;
                  end else begin
                     tx_scnt <= tx_scnt + 8'd1;
                  end
               end
            end
         endcase
      end
   end

   // Payload length (bytes after the command code) for a candidate command.
   always_comb begin
      cmd_valid = 1'b1;
      cmd_len   = 8'd2;
      case (rx_data)
         CMD_DATA:                         cmd_len = DATA_LEN;
         CMD_FREQ:                         cmd_len = FREQ_LEN;
         CMD_PERIOD, CMD_CTRL, CMD_REPEAT: cmd_len = 8'd2;
         default:                          cmd_valid = 1'b0;
      endcase
   end

   // Command decoder. Payload bytes collect in shadow registers: the first
   // payload byte in sh_first, every byte shifted in from the top of sh_data
   // so multi-byte patterns end up LSB-byte-first. Outputs change only on the
   // final byte, so a partial or aborted packet leaves them untouched.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         dec_state <= DEC_IDLE;
         cmd_reg   <= '0;
         len_reg   <= '0;
         byte_cnt  <= '0;
         sh_first  <= '0;
         sh_data   <= '0;
         pattern   <= '0;
         freq      <= '0;
         sel       <= '0;
         mode      <= '0;
         enable    <= 1'b0;
         stop      <= 1'b0;
         idle      <= 1'b0;
         slow      <= '0;
         fast      <= '0;
         rep       <= '0;
         cmd_out   <= '0;
         done_tick <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
         idle_cnt  <= '0;
`endif
      end else begin
         done_tick <= 1'b0;
         if (dec_state == DEC_IDLE) begin
            if (rx_done && cmd_valid) begin
               cmd_reg   <= rx_data;
               len_reg   <= cmd_len;
               byte_cnt  <= '0;
               dec_state <= DEC_PAYLOAD;
`ifdef UART_CMD_TIMEOUT_EN
               idle_cnt  <= '0;
`endif
            end
         end else if (rx_done) begin
`ifdef UART_CMD_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            byte_cnt <= byte_cnt + 8'd1;
            sh_data  <= {rx_data, sh_data[DATA_BIT-9:8]};
            if (byte_cnt == 8'd0) sh_first <= rx_data;
            if (byte_cnt == len_reg - 8'd1) begin
               case (cmd_reg)
                  CMD_DATA: begin
                     sel     <= sh_first;
                     pattern <= {rx_data, sh_data};
                  end
                  CMD_FREQ: freq <= {rx_data, sh_data};
                  CMD_PERIOD: begin
                     slow <= sh_first;
                     fast <= rx_data;
                  end
                  CMD_CTRL: begin
                     sel    <= sh_first;
                     enable <= rx_data[0];
                     mode   <= rx_data[2:1];
                     idle   <= rx_data[3];
                     stop   <= rx_data[4];
                  end
                  default: begin
                     sel <= sh_first;
                     rep <= rx_data;
                  end
               endcase
               cmd_out   <= cmd_reg;
               done_tick <= 1'b1;
               dec_state <= DEC_IDLE;
            end
`ifdef UART_CMD_TIMEOUT_EN
         end else if (tick) begin
            if (idle_cnt == 9'd319) dec_state <= DEC_IDLE;
            else                    idle_cnt  <= idle_cnt + 9'd1;
`endif
         end
      end
   end

   assign bus.tx_o             = tx_line;
   assign bus.rx_done_tick_o   = rx_done;
   assign bus.rx_data_o        = rx_data;
   assign bus.tx_done_tick_o   = tx_done;
   assign bus.output_pattern_o = pattern;
   assign bus.freq_pattern_o   = freq;
   assign bus.sel_out_o        = sel;
   assign bus.mode_o           = mode;
   assign bus.enable_o         = enable;
   assign bus.stop_o           = stop;
   assign bus.idle_o           = idle;
   assign bus.slow_period_o    = slow;
   assign bus.fast_period_o    = fast;
   assign bus.repeat_o         = rep;
   assign bus.cmd_o            = cmd_out;
   assign bus.done_tick_o      = done_tick;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_decoder
// Drives 8N1 frames into uart_cmd_decoder, decodes the echo on tx_o, and
// compares the decoded registers with a packet-level reference model.
// A fast clock ratio (2 clocks per baud tick, 32 clocks per bit) keeps runs
// short. Define UART_CMD_TIMEOUT_EN to also exercise the packet timeout.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_cmd_decoder;
   localparam int BAUD = 115200;
   localparam int SYS  = 3686400;
   localparam int BITC = 32;
   localparam int BITNS = BITC * 10;

   typedef struct {
      int         n;
      logic [7:0] b [6];
      int         field;
      logic [63:0] expVal;
      logic [7:0] expCmd;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_cmd_decoder_if #(.DATA_BIT(32)) bus ();

   uart_cmd_decoder #(
      .SYS_CLK(SYS), .BAUD_RATE(BAUD), .DATA_BIT(32), .PACK_NUM(4), .STOP_BIT(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int testsRun = 0;
   int testsFailed = 0;
   int rxDoneCnt = 0, txDoneCnt = 0, doneCnt = 0, bytesSent = 0;
   logic [7:0] echoQ[$];
   vec_t vecs[8];

   // Reference model state: the bytes of the packet under construction and
   // the register values that completed packets have produced.
   logic [7:0]  pendQ[$];
   logic [31:0] mPattern, mFreq;
   logic [7:0]  mSel, mSlow, mFast, mRepeat, mCmd;
   logic [1:0]  mMode;
   logic        mEnable, mStop, mIdle;
   int          mDone = 0;

   // Pulse counters, sampled on the falling clock edge.
   always @(negedge clk) begin
      if (bus.rx_done_tick_o === 1'b1) rxDoneCnt++;
      if (bus.tx_done_tick_o === 1'b1) txDoneCnt++;
      if (bus.done_tick_o === 1'b1)    doneCnt++;
   end

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Echo decoder: behaves like a host UART receiver sampling mid-bit.
   initial begin
      logic [7:0] data;
      logic       stopBit;
      forever begin
         @(negedge bus.tx_o);
         #(BITNS + BITNS / 2);
         for (int i = 0; i < 8; i++) begin
            data[i] = bus.tx_o;
            #(BITNS);
         end
         stopBit = bus.tx_o;
         if (echoQ.size() == 0) checkOutput("echo_unexpected", {1'b1, data}, 128'h0);
         else                   checkOutput("echo_byte", {stopBit, data}, {1'b1, echoQ.pop_front()});
      end
   end

   initial begin
      #(900us);
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int payloadLen(input logic [7:0] c);
      case (c)
         8'h01:               return 5;
         8'h02:               return 4;
         8'h03, 8'h04, 8'h05: return 2;
         default:             return 0;
      endcase
   endfunction

   task automatic modelReset();
      pendQ.delete();
      mPattern = '0; mFreq = '0; mSel = '0; mSlow = '0; mFast = '0;
      mRepeat = '0; mCmd = '0; mMode = '0; mEnable = 0; mStop = 0; mIdle = 0;
   endtask

   task automatic modelByte(input logic [7:0] b);
      logic [7:0] c;
      if (pendQ.size() == 0) begin
         if (payloadLen(b) > 0) pendQ.push_back(b);
         return;
      end
      pendQ.push_back(b);
      if (pendQ.size() != payloadLen(pendQ[0]) + 1) return;
      case (pendQ[0])
         8'h01: begin
            mSel = pendQ[1];
            mPattern = 0;
            for (int k = 0; k < 4; k++) mPattern += 32'(pendQ[2 + k]) * (32'd1 << (8 * k));
         end
         8'h02: begin
            mFreq = 0;
            for (int k = 0; k < 4; k++) mFreq += 32'(pendQ[1 + k]) * (32'd1 << (8 * k));
         end
         8'h03: begin mSlow = pendQ[1]; mFast = pendQ[2]; end
         8'h04: begin
            mSel = pendQ[1]; c = pendQ[2];
            mEnable = c[0]; mMode = c[2:1]; mIdle = c[3]; mStop = c[4];
         end
         default: begin mSel = pendQ[1]; mRepeat = pendQ[2]; end
      endcase
      mCmd = pendQ[0];
      mDone++;
      pendQ.delete();
   endtask

   function automatic logic [127:0] modelVector();
      return {mPattern, mFreq, mSel, mMode, mEnable, mStop, mIdle, mSlow, mFast, mRepeat, mCmd};
   endfunction

   function automatic logic [127:0] dutVector();
      return {bus.output_pattern_o, bus.freq_pattern_o, bus.sel_out_o, bus.mode_o,
              bus.enable_o, bus.stop_o, bus.idle_o, bus.slow_period_o,
              bus.fast_period_o, bus.repeat_o, bus.cmd_o};
   endfunction

   // Sends one 8N1 frame plus one idle bit, then checks the receive side and
   // the decoded registers against the model.
   task automatic applyStimulus(input logic [7:0] b);
      int startRx = rxDoneCnt;
      echoQ.push_back(b);
      bytesSent++;
      bus.rx_i = 1'b0;
      repeat (BITC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.rx_i = b[i];
         repeat (BITC) @(negedge clk);
      end
      bus.rx_i = 1'b1;
      repeat (2 * BITC) @(negedge clk);
      modelByte(b);
      checkOutput("rx_done_once", 128'(rxDoneCnt - startRx), 128'd1);
      checkOutput("rx_data", 128'(bus.rx_data_o), 128'(b));
      checkOutput("outputs_vs_model", dutVector(), modelVector());
      checkOutput("done_count", 128'(doneCnt), 128'(mDone));
   endtask

   task automatic setVec(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                         input logic [7:0] b5, input int field, input logic [63:0] v,
                         input logic [7:0] cmd);
      vecs[i].n = n;
      vecs[i].b[0] = b0; vecs[i].b[1] = b1; vecs[i].b[2] = b2;
      vecs[i].b[3] = b3; vecs[i].b[4] = b4; vecs[i].b[5] = b5;
      vecs[i].field = field; vecs[i].expVal = v; vecs[i].expCmd = cmd;
   endtask

   initial begin
      logic [63:0] actual;
      logic [7:0]  c;
      int          prevDone;

      // field: 0 {slow,fast} 1 freq 2 {sel,pattern} 3 {sel,repeat}
      //        4 {sel,stop,idle,mode,enable} 5 ignored byte
      setVec(0, 3, 8'h03, 8'h14, 8'h05, 0, 0, 0, 0, 64'h1405, 8'h03);
      setVec(1, 5, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 0, 1, 64'h11223344, 8'h02);
      setVec(2, 6, 8'h01, 8'h05, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 2, 64'h05BBCCDDEE, 8'h01);
      setVec(3, 3, 8'h05, 8'h05, 8'h03, 0, 0, 0, 3, 64'h0503, 8'h05);
      setVec(4, 3, 8'h04, 8'h05, 8'h0B, 0, 0, 0, 4, 64'h0AB, 8'h04);
      setVec(5, 1, 8'h7F, 0, 0, 0, 0, 0, 5, 64'h0, 8'h04);
      setVec(6, 6, 8'h01, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 2, 64'h0304030201, 8'h01);
      setVec(7, 3, 8'h04, 8'h02, 8'hFF, 0, 0, 0, 4, 64'h05F, 8'h04);

      bus.rx_i = 1'b1;
      modelReset();
      #1 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("reset_outputs", dutVector(), 128'h0);
      checkOutput("reset_tx_idle", 128'(bus.tx_o), 128'd1);
      checkOutput("reset_rx_data", 128'(bus.rx_data_o), 128'd0);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         prevDone = doneCnt;
         for (int j = 0; j < vecs[i].n; j++) applyStimulus(vecs[i].b[j]);
         case (vecs[i].field)
            0:       actual = 64'({bus.slow_period_o, bus.fast_period_o});
            1:       actual = 64'(bus.freq_pattern_o);
            2:       actual = 64'({bus.sel_out_o, bus.output_pattern_o});
            3:       actual = 64'({bus.sel_out_o, bus.repeat_o});
            4:       actual = 64'({bus.sel_out_o, bus.stop_o, bus.idle_o, bus.mode_o, bus.enable_o});
            default: actual = 64'h0;
         endcase
         checkOutput($sformatf("vec%0d_value", i), 128'(actual), 128'(vecs[i].expVal));
         checkOutput($sformatf("vec%0d_cmd", i), 128'(bus.cmd_o), 128'(vecs[i].expCmd));
         checkOutput($sformatf("vec%0d_done_delta", i), 128'(doneCnt - prevDone),
                     (vecs[i].field == 5) ? 128'd0 : 128'd1);
      end

      // Reset in the middle of a PERIOD packet discards it.
      applyStimulus(8'h03);
      applyStimulus(8'h14);
      repeat (14 * BITC) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("midpacket_reset_outputs", dutVector(), 128'h0);
      checkOutput("midpacket_reset_tx", 128'(bus.tx_o), 128'd1);
      rst_n = 1'b0;
      modelReset();
      repeat (3) @(negedge clk);
      applyStimulus(8'h03);
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      checkOutput("after_reset_period", 128'({bus.slow_period_o, bus.fast_period_o}), 128'h0102);

      // A start-bit glitch shorter than half a bit must not produce a byte.
      prevDone = rxDoneCnt;
      bus.rx_i = 1'b0;
      repeat (6) @(negedge clk);
      bus.rx_i = 1'b1;
      repeat (12 * BITC) @(negedge clk);
      checkOutput("glitch_rejected", 128'(rxDoneCnt - prevDone), 128'd0);

`ifdef UART_CMD_TIMEOUT_EN
      prevDone = doneCnt;
      applyStimulus(8'h02);
      repeat (22 * BITC) @(negedge clk);
      pendQ.delete();
      applyStimulus(8'h03);
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      checkOutput("timeout_then_period", 128'({bus.slow_period_o, bus.fast_period_o}), 128'h0102);
      checkOutput("timeout_done_delta", 128'(doneCnt - prevDone), 128'd1);
`endif

      // Random packets (including junk command bytes) against the model.
      for (int r = 0; r < 16; r++) begin
         c = 8'($urandom_range(0, 6));
         if (c == 8'd0 || c == 8'd6) begin
            c = 8'($urandom_range(6, 255));
            applyStimulus(c);
         end else begin
            applyStimulus(c);
            for (int k = 0; k < payloadLen(c); k++) applyStimulus(8'($urandom_range(0, 255)));
         end
      end

      repeat (14 * BITC) @(negedge clk);
      checkOutput("echo_all_seen", 128'(echoQ.size()), 128'd0);
      checkOutput("rx_done_total", 128'(rxDoneCnt), 128'(bytesSent));
      checkOutput("tx_done_total", 128'(txDoneCnt), 128'(bytesSent));
      checkOutput("final_outputs", dutVector(), modelVector());

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
